// File: rtl/rs232_rx_fifo.sv
// RS-232 receive path: 16x-oversampled 8N1 deserialiser feeding a
// first-word-fall-through byte FIFO for the PicoBlaze input port.
module rs232_rx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rs232_rx,
  output logic [7:0] rx_data_out,
  input  logic       read_rx_data_ack,
  output logic       rx_data_present,
  output logic       rx_buffer_full,
  output logic       rx_buffer_half_full,
  output logic       framing_error,
  output logic       overrun_error
);

  localparam int DIV   = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic             rx_meta;
  logic             rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic             en_16x;
  state_t           state;
  state_t           state_n;
  logic [3:0]       tick_cnt;
  logic [3:0]       tick_n;
  logic [2:0]       bit_cnt;
  logic [2:0]       bit_n;
  logic [7:0]       shift;
  logic [7:0]       shift_n;
  logic             stop_ok;
  logic             stop_bad;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  // Two-stage synchroniser; it only delays the line, so it needs no reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    rx_meta <= rs232_rx;
    rx_s    <= rx_meta;
  end

  assign en_16x = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)       div_cnt <= '0;
    else if (en_16x) div_cnt <= '0;
    else             div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_WAIT_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
    end
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_n  = state;
    tick_n   = tick_cnt;
    bit_n    = bit_cnt;
    shift_n  = shift;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    if (en_16x) begin
      unique case (state)
        S_WAIT_IDLE: if (rx_s) state_n = S_IDLE;
        S_IDLE: begin
          if (!rx_s) begin
            state_n = S_START;
            tick_n  = '0;
          end
        end
        S_START: begin
          tick_n = tick_cnt + 4'd1;
          if (tick_cnt == 4'd7) begin
            if (rx_s) begin
              state_n = S_IDLE;
            end else begin
              state_n = S_DATA;
              tick_n  = '0;
              bit_n   = '0;
            end
          end
        end
        S_DATA: begin
          tick_n = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            shift_n = {rx_s, shift[7:1]};
            bit_n   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_n = S_STOP;
          end
        end
        S_STOP: begin
          tick_n = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            stop_ok  = rx_s;
            stop_bad = !rx_s;
            state_n  = rx_s ? S_IDLE : S_WAIT_IDLE;
          end
        end
        default: state_n = S_WAIT_IDLE;
      endcase
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign pop  = read_rx_data_ack && (count != '0);
  assign push = stop_ok && (!rx_buffer_full || pop);

  // NOTE: the storage array is not reset; count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      framing_error <= stop_bad;
      overrun_error <= stop_ok && !push;
    end
  end

  assign rx_data_out         = mem[rd_ptr];
  assign rx_data_present     = (count != '0);
  assign rx_buffer_full      = (count == CW'(FIFO_DEPTH));
  assign rx_buffer_half_full = (count >= CW'(FIFO_DEPTH / 2));

endmodule
